uart_rx_framed: RTL and testbench
=================================

# uart_rx_framed

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds runtime baud divisor, 5–9 data bits, optional parity, stop-bit checking, false-start rejection and a valid/ready output register with overrun reporting. Sits between the pad-side RX line and the wishbone UART register block, which drains received words through the handshake.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first
- DIV_W, 16, width of the runtime bit-period divisor
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rx_w  in  1  asynchronous serial line; idle high
- i_cycles_per_bit  in  DIV_W  clock cycles per bit; legal ≥ 4; latched at start detect
- i_parity_en  in  1  frame carries a parity bit (only with UART_RX_PARITY_EN)
- i_parity_odd  in  1  1 = odd parity, 0 = even (only with UART_RX_PARITY_EN)
- o_data_w  out  DATA_BITS  received word, stable while o_data_valid high
- o_data_valid  out  1  word available
- i_data_ready  in  1  consumer accepts word when valid & ready
- o_busy  out  1  high in any state other than IDLE
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without macro)
- o_overrun  out  1  one-cycle pulse: good word completed while output register full

## Operation
- i_rx_w passes a 2-FF synchronizer (reset value 1); falling-edge detect on synchronized line.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: on falling edge, latch i_cycles_per_bit into div_q, load counter with (div_q>>1)-1, go START.
- START: at counter 0 sample line; low → counter = div_q-1, bit index 0, DATA; high → false start, IDLE, no flags.
- DATA: at each counter 0 sample into shift register bit[index]; after index DATA_BITS-1 go PARITY if parity enabled, else STOP.
- PARITY: sample; expected = XOR(data) ^ i_parity_odd; mismatch sets pending parity error.
- STOP: sample at mid-bit. Then, in same cycle, go IDLE (re-arm at mid-stop so back-to-back frames are not lost).
  - Stop low → o_frame_err pulse, word discarded, parity error not reported.
  - Stop high, parity error pending → o_parity_err pulse, word discarded.
  - Stop high, no error: if output register empty or being accepted this cycle (valid & ready) → load o_data_w, o_data_valid=1; else o_overrun pulse, new word discarded, held word unchanged.
- Output register: o_data_valid clears on valid & ready unless a new word loads in the same cycle (load wins, valid stays 1).
- Break (line held low): after frame error, IDLE waits for a new falling edge, so a held-low line produces exactly one frame error.
- Counter arithmetic DIV_W bits, unsigned, no wrap: reloaded at every 0.

## Timing
- Reset (async assert, sync release): state IDLE, o_data_w 0, o_data_valid 0, o_busy 0, all error pulses 0, sync regs 1.
- Start edge to START entry: 3 cycles (2 sync + edge register).
- Data sample points: mid-bit, div_q cycles apart, relative to detected edge.
- o_data_valid / error pulses assert the cycle after the stop sample; pulses last exactly 1 cycle.
- o_busy falls the cycle after the stop sample.
- i_cycles_per_bit changes mid-frame ignored until next start.
- Reset mid-frame: partial word dropped, no flags.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state, i_parity_en/i_parity_odd ports and o_parity_err logic present.
- Undefined: ports i_parity_en/i_parity_odd absent, PARITY state never entered, o_parity_err tied 0; frame is start + DATA_BITS + stop.

## Structure
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), parity-mode constants, min-divisor constant (4).
- Sub-module uart_rx_sync: 2-FF synchronizer with reset-to-1 and falling-edge pulse output; reusable by future RX variants.

## Test plan
- Divisor 16, 8N1, send 0xA5, ready held 1 → o_data_w=0xA5, valid 1 cycle, no flags.
- Divisor 16, send 0x3C then 0x5A back-to-back, ready 0 → 0x3C held, o_overrun 1 pulse, valid stays 1, data stays 0x3C.
- Divisor 16, 2-cycle low glitch on idle line → no valid, no flags, o_busy returns 0 within 11 cycles.
- Divisor 10, send 0x81 with stop bit forced low → o_frame_err 1 pulse, valid stays 0; line held low 100 cycles → no second error.
- UART_RX_PARITY_EN, odd parity, send 0x07 with parity bit 1 (wrong) → o_parity_err pulse, no valid; with parity bit 0 → valid, data 0x07.
- DATA_BITS=5, divisor 4, send 0x15; assert reset mid-frame on second frame → first word 0x15, second dropped, all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding, parity modes and divisor limit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int unsigned MIN_CYCLES_PER_BIT = 4;

    // Expected parity bit for a word zero-extended to 9 bits.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// rtl/uart_rx_framed_if.sv - received-word valid/ready handshake between receiver and register block
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data_w;
    logic                 o_data_valid;
    logic                 i_data_ready;

    modport master (
        output o_data_w,
        output o_data_valid,
        input  i_data_ready
    );

    modport slave (
        input  o_data_w,
        input  o_data_valid,
        output i_data_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF line synchronizer (resets to idle-high) with registered falling-edge pulse
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx_w,
    output logic o_rx,
    output logic o_fall
);
    logic meta_q;
    logic sync_q;
    logic fall_q;

    // fall_q rises together with sync_q going low, so the edge is seen 2 cycles after the pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= i_rx_w;
            sync_q <= meta_q;
            fall_q <= sync_q & ~meta_q;
        end
    end

    assign o_rx   = sync_q;
    assign o_fall = fall_q;
endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - framed UART receiver, runtime divisor, 5..9 data bits; parity under UART_RX_PARITY_EN
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_w,
    input  logic [DIV_W-1:0] i_cycles_per_bit,
`ifdef UART_RX_PARITY_EN
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
`endif
    uart_rx_framed_if.master out_if,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_overrun
);
    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_START  = 3'(ST_START);
    localparam logic [2:0] S_DATA   = 3'(ST_DATA);
    localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
    localparam int         IDX_W    = $clog2(DATA_BITS);

    logic                 rx_s, fall_s, tick, par_en, par_odd;
    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_err_q, par_err_d, valid_q, valid_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;

`ifdef UART_RX_PARITY_EN
    assign par_en  = i_parity_en;
    assign par_odd = i_parity_odd;
`else
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx_w  (i_rx_w),
        .o_rx    (rx_s),
        .o_fall  (fall_s)
    );

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = valid_q & ~out_if.i_data_ready;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        ovr_d     = 1'b0;
        if (!tick) cnt_d = cnt_q - DIV_W'(1);
        case (state_q)
            S_IDLE: if (fall_s) begin
                div_d     = i_cycles_per_bit;
                cnt_d     = (i_cycles_per_bit >> 1) - DIV_W'(1);
                par_err_d = 1'b0;
                state_d   = S_START;
            end
            S_START: if (tick) begin
                if (!rx_s) begin
                    cnt_d   = div_q - DIV_W'(1);
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: if (tick) begin
                // LSB arrives first, so shifting in from the top leaves it at bit 0.
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                cnt_d   = div_q - DIV_W'(1);
                if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = par_en ? S_PARITY : S_STOP;
                else                                idx_d   = idx_q + IDX_W'(1);
            end
            S_PARITY: if (tick) begin
                par_err_d = (rx_s != parity_bit(9'(shift_q), par_odd));
                cnt_d     = div_q - DIV_W'(1);
                state_d   = S_STOP;
            end
            S_STOP: if (tick) begin
                // Back to IDLE at mid-stop so a start bit right after this stop bit is caught.
                state_d = S_IDLE;
                if (!rx_s)                                 ferr_d = 1'b1;
                else if (par_err_q)                        perr_d = 1'b1;
                else if (!valid_q || out_if.i_data_ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else                                   ovr_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign out_if.o_data_w     = data_q;
    assign out_if.o_data_valid = valid_q;
    assign o_busy              = (state_q != S_IDLE);
    assign o_frame_err         = ferr_q;
    assign o_parity_err        = perr_q;
    assign o_overrun           = ovr_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - self-checking bench for uart_rx_framed (8-bit and 5-bit instances; parity under UART_RX_PARITY_EN)
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n_a, rst_n_b, rx_a, rx_b;
    logic [DIV_W-1:0] div_a, div_b;
    logic             busy_a, ferr_a, perr_a, ovr_a;
    logic             busy_b, ferr_b, perr_b, ovr_b;
`ifdef UART_RX_PARITY_EN
    logic             par_en_a, par_odd_a, par_en_b, par_odd_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int va = 0, fa = 0, pa = 0, oa = 0;
    int vb = 0, fb = 0, pb = 0, ob = 0;
    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];

    uart_rx_framed_if #(.DATA_BITS(8)) a_if();
    uart_rx_framed_if #(.DATA_BITS(5)) b_if();

    uart_rx_framed #(.DATA_BITS(8), .DIV_W(DIV_W)) dut_a (
        .i_clk            (clk),
        .i_rst_n          (rst_n_a),
        .i_rx_w           (rx_a),
        .i_cycles_per_bit (div_a),
`ifdef UART_RX_PARITY_EN
        .i_parity_en      (par_en_a),
        .i_parity_odd     (par_odd_a),
`endif
        .out_if           (a_if),
        .o_busy           (busy_a),
        .o_frame_err      (ferr_a),
        .o_parity_err     (perr_a),
        .o_overrun        (ovr_a)
    );

    uart_rx_framed #(.DATA_BITS(5), .DIV_W(DIV_W)) dut_b (
        .i_clk            (clk),
        .i_rst_n          (rst_n_b),
        .i_rx_w           (rx_b),
        .i_cycles_per_bit (div_b),
`ifdef UART_RX_PARITY_EN
        .i_parity_en      (par_en_b),
        .i_parity_odd     (par_odd_b),
`endif
        .out_if           (b_if),
        .o_busy           (busy_b),
        .o_frame_err      (ferr_b),
        .o_parity_err     (perr_b),
        .o_overrun        (ovr_b)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard side: count pulses/valid cycles, pop and compare on each accepted word.
    always @(negedge clk) begin
        if (rst_n_a) begin
            if (a_if.o_data_valid) va++;
            if (ferr_a) fa++;
            if (perr_a) pa++;
            if (ovr_a)  oa++;
            if (a_if.o_data_valid && a_if.i_data_ready) begin
                check("a_word_expected", 32'(sb_a.size() != 0), 1);
                if (sb_a.size() != 0) check("a_word", 32'(a_if.o_data_w), 32'(sb_a.pop_front()));
            end
        end
        if (rst_n_b) begin
            if (b_if.o_data_valid) vb++;
            if (ferr_b) fb++;
            if (perr_b) pb++;
            if (ovr_b)  ob++;
            if (b_if.o_data_valid && b_if.i_data_ready) begin
                check("b_word_expected", 32'(sb_b.size() != 0), 1);
                if (sb_b.size() != 0) check("b_word", 32'(b_if.o_data_w), 32'(sb_b.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_line(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    task automatic send_frame(input bit to_b, input logic [8:0] data, input int nbits, input int div,
                              input bit with_par, input logic par_bit, input logic stop_bit, input int alt_div);
        if (to_b) div_b = DIV_W'(div);
        else      div_a = DIV_W'(div);
        set_line(to_b, 1'b0);
        repeat (div) step();
        if (alt_div != 0) begin
            if (to_b) div_b = DIV_W'(alt_div);
            else      div_a = DIV_W'(alt_div);
        end
        for (int i = 0; i < nbits; i++) begin
            set_line(to_b, data[i]);
            repeat (div) step();
        end
        if (with_par) begin
            set_line(to_b, par_bit);
            repeat (div) step();
        end
        set_line(to_b, stop_bit);
        repeat (div) step();
        if (to_b) div_b = DIV_W'(div);
        else      div_a = DIV_W'(div);
    endtask

    task automatic wait_idle(input bit to_b, input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (to_b ? (!busy_b && sb_b.size() == 0) : (!busy_a && sb_a.size() == 0)) break;
            step();
        end
        check(name, 32'(k < 400), 1);
    endtask

    typedef struct {
        logic [8:0] data;
        int         div;
        int         alt_div;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, f0, p0, o0, done;
        bit seen;

        vecs[0] = '{9'h0A5, 16, 0,  9'h0A5};
        vecs[1] = '{9'h000, 16, 20, 9'h000};
        vecs[2] = '{9'h0FF, 12, 40, 9'h0FF};
        vecs[3] = '{9'h03C, 7,  0,  9'h03C};
        vecs[4] = '{9'h081, 4,  9,  9'h081};
        vecs[5] = '{9'h06E, 5,  0,  9'h06E};

        rx_a = 1'b1; rx_b = 1'b1;
        div_a = 16; div_b = 4;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        a_if.i_data_ready = 1'b1;
        b_if.i_data_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_en_a = 1'b0; par_odd_a = PARITY_EVEN;
        par_en_b = 1'b0; par_odd_b = PARITY_EVEN;
`endif
        repeat (3) step();
        check("rst_data",   32'(a_if.o_data_w), 0);
        check("rst_valid",  32'(a_if.o_data_valid), 0);
        check("rst_busy",   32'(busy_a), 0);
        check("rst_ferr",   32'(ferr_a), 0);
        check("rst_perr",   32'(perr_a), 0);
        check("rst_ovr",    32'(ovr_a), 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (4) step();

        // Table: 8N1 words at several divisors, ready held high, divisor disturbed mid-frame.
        for (int i = 0; i < 6; i++) begin
            v0 = va; f0 = fa; p0 = pa; o0 = oa;
            sb_a.push_back(vecs[i].exp);
            send_frame(1'b0, vecs[i].data, 8, vecs[i].div, 1'b0, 1'b0, 1'b1, vecs[i].alt_div);
            wait_idle(1'b0, "vec_done");
            check("vec_valid_cycles", 32'(va - v0), 1);
            check("vec_data_held",    32'(a_if.o_data_w), 32'(vecs[i].exp));
            check("vec_no_flags",     32'((fa - f0) + (pa - p0) + (oa - o0)), 0);
            repeat (3) step();
        end

        // Back-to-back frames with the consumer stalled: second word overruns.
        a_if.i_data_ready = 1'b0;
        v0 = va; f0 = fa; o0 = oa;
        sb_a.push_back(9'h03C);
        send_frame(1'b0, 9'h03C, 8, 16, 1'b0, 1'b0, 1'b1, 0);
        send_frame(1'b0, 9'h05A, 8, 16, 1'b0, 1'b0, 1'b1, 0);
        repeat (20) step();
        check("ovr_pulses",  32'(oa - o0), 1);
        check("ovr_valid",   32'(a_if.o_data_valid), 1);
        check("ovr_data",    32'(a_if.o_data_w), 'h3C);
        check("ovr_no_ferr", 32'(fa - f0), 0);
        a_if.i_data_ready = 1'b1;
        step();
        check("ovr_drained",     32'(sb_a.size()), 0);
        check("ovr_valid_clear", 32'(a_if.o_data_valid), 0);
        repeat (4) step();

        // Two-cycle low glitch: false start, back to IDLE by cycle 11, nothing reported.
        div_a = 16;
        v0 = va; f0 = fa; p0 = pa; o0 = oa;
        seen = 1'b0; done = 0;
        rx_a = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 2) rx_a = 1'b1;
            if (busy_a) seen = 1'b1;
            else if (seen && done == 0) done = k;
        end
        check("glitch_busy_seen", 32'(seen), 1);
        check("glitch_idle_by_11", 32'(done != 0), 1);
        repeat (10) step();
        check("glitch_no_output", 32'((va - v0) + (fa - f0) + (pa - p0) + (oa - o0)), 0);

        // Stop bit low, then break: exactly one frame error, no word.
        v0 = va; f0 = fa;
        send_frame(1'b0, 9'h081, 8, 10, 1'b0, 1'b0, 1'b0, 0);
        repeat (100) step();
        check("ferr_pulses",       32'(fa - f0), 1);
        check("ferr_no_valid",     32'(va - v0), 0);
        check("ferr_busy_in_break", 32'(busy_a), 0);
        rx_a = 1'b1;
        repeat (10) step();
        check("ferr_after_release", 32'(fa - f0), 1);

`ifdef UART_RX_PARITY_EN
        par_en_a = 1'b1; par_odd_a = PARITY_ODD;
        v0 = va; p0 = pa;
        send_frame(1'b0, 9'h007, 8, 16, 1'b1, 1'b1, 1'b1, 0);
        repeat (20) step();
        check("par_bad_pulse",    32'(pa - p0), 1);
        check("par_bad_no_valid", 32'(va - v0), 0);
        v0 = va; p0 = pa;
        sb_a.push_back(9'h007);
        send_frame(1'b0, 9'h007, 8, 16, 1'b1, 1'b0, 1'b1, 0);
        wait_idle(1'b0, "par_good_done");
        check("par_good_valid",  32'(va - v0), 1);
        check("par_good_no_err", 32'(pa - p0), 0);
        check("par_good_data",   32'(a_if.o_data_w), 'h07);
        par_odd_a = PARITY_EVEN;
        v0 = va; p0 = pa;
        sb_a.push_back(9'h007);
        send_frame(1'b0, 9'h007, 8, 16, 1'b1, 1'b1, 1'b1, 0);
        wait_idle(1'b0, "par_even_done");
        check("par_even_valid",  32'(va - v0), 1);
        check("par_even_no_err", 32'(pa - p0), 0);
        par_en_a = 1'b0;
        repeat (4) step();
`endif

        // 5-bit instance at the minimum divisor, then reset in the middle of the next frame.
        v0 = vb;
        sb_b.push_back(9'h015);
        send_frame(1'b1, 9'h015, 5, int'(MIN_CYCLES_PER_BIT), 1'b0, 1'b0, 1'b1, 0);
        wait_idle(1'b1, "b_done");
        check("b_valid_cycles", 32'(vb - v0), 1);
        check("b_word_held",    32'(b_if.o_data_w), 'h15);
        v0 = vb; f0 = fb; p0 = pb; o0 = ob;
        rx_b = 1'b0; repeat (4) step();
        rx_b = 1'b1; repeat (4) step();
        rx_b = 1'b0; repeat (2) step();
        check("b_busy_midframe", 32'(busy_b), 1);
        rst_n_b = 1'b0;
        #1;
        check("b_rst_data",  32'(b_if.o_data_w), 0);
        check("b_rst_valid", 32'(b_if.o_data_valid), 0);
        check("b_rst_busy",  32'(busy_b), 0);
        check("b_rst_flags", 32'({ferr_b, perr_b, ovr_b}), 0);
        rx_b = 1'b1;
        repeat (3) step();
        rst_n_b = 1'b1;
        repeat (40) step();
        check("b_dropped_no_output", 32'((vb - v0) + (fb - f0) + (pb - p0) + (ob - o0)), 0);
        check("b_idle_after_reset",  32'(busy_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
